// File: rtl/led_shift_monitor.sv
// led_shift_monitor: receive-side checker for a rotating 8-bit LED pattern.
// Synchronises the remote leds bus, locks onto INIT_PATTERN, then checks
// that each change is a one-bit left rotation arriving on schedule.
module led_shift_monitor #(
  parameter int unsigned CLK_FREQ     = 8,
  parameter int unsigned STEP_CYCLES  = CLK_FREQ / 4,
  parameter int unsigned TOL          = 0,
  parameter logic [7:0]  INIT_PATTERN = 8'h1F,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  leds_in,
  input  logic        err_clr,
  output logic        locked,
  output logic        step_pulse,
  output logic [15:0] step_count,
  output logic [2:0]  position,
  output logic [7:0]  last_pattern,
  output logic        pattern_err,
  output logic        timing_err,
  output logic        err_sticky
);

  localparam logic [7:0] STEP_LO = 8'(STEP_CYCLES - TOL);
  localparam logic [7:0] STEP_HI = 8'(STEP_CYCLES + TOL);

  typedef enum logic [1:0] {
    SEARCH,
    ALIGN,
    TRACK,
    FAULT
  } state_t;

  state_t     state;
  logic [7:0] sync_q [SYNC_STAGES];
  logic [7:0] leds_s;
  logic [7:0] prev;
  logic [7:0] cnt;
  logic [7:0] rot_prev;
  logic [7:0] cnt_inc;
  logic       change;
  logic       rot_ok;
  logic       early;
  logic       overdue;
  logic       accept;

  // Multi-flop synchroniser for the asynchronous remote bus
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= leds_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign leds_s = sync_q[SYNC_STAGES-1];

  // Change classification against the last accepted pattern
  always_comb begin
    rot_prev = {prev[6:0], prev[7]};
    change   = (leds_s != prev);
    rot_ok   = (leds_s == rot_prev);
    early    = (cnt < STEP_LO);
    overdue  = (cnt == STEP_HI);
    cnt_inc  = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    // ALIGN has no timing window; TRACK rejects early changes
    accept   = change && rot_ok &&
               ((state == ALIGN) || ((state == TRACK) && !early));
  end

  // Tracking FSM with registered status, counters and error pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= SEARCH;
      prev         <= '0;
      cnt          <= '0;
      locked       <= 1'b0;
      step_pulse   <= 1'b0;
      step_count   <= '0;
      position     <= '0;
      last_pattern <= '0;
      pattern_err  <= 1'b0;
      timing_err   <= 1'b0;
      err_sticky   <= 1'b0;
    end else begin
      step_pulse  <= 1'b0;
      pattern_err <= 1'b0;
      timing_err  <= 1'b0;
      cnt         <= cnt_inc;
      // Error branches below reassign err_sticky, so they win over err_clr
      if (err_clr) err_sticky <= 1'b0;

      if (accept) begin
        prev         <= leds_s;
        last_pattern <= leds_s;
        step_pulse   <= 1'b1;
        step_count   <= (step_count == 16'hFFFF) ? step_count : step_count + 16'd1;
        position     <= position + 3'd1;
        cnt          <= 8'd1;
      end

      case (state)
        SEARCH: begin
          if (leds_s == INIT_PATTERN) begin
            prev         <= INIT_PATTERN;
            last_pattern <= INIT_PATTERN;
            position     <= '0;
            step_count   <= '0;
            cnt          <= 8'd1;
            state        <= ALIGN;
          end
        end
        ALIGN: begin
          if (change) begin
            if (rot_ok) begin
              locked <= 1'b1;
              state  <= TRACK;
            end else begin
              pattern_err <= 1'b1;
              err_sticky  <= 1'b1;
              state       <= SEARCH;
            end
          end
        end
        TRACK: begin
          if (change) begin
            if (!rot_ok || early) begin
              pattern_err <= !rot_ok;
              timing_err  <= early;
              err_sticky  <= 1'b1;
              locked      <= 1'b0;
              state       <= FAULT;
            end
          end else if (overdue) begin
            timing_err <= 1'b1;
            err_sticky <= 1'b1;
            locked     <= 1'b0;
            state      <= FAULT;
          end
        end
        FAULT: begin
          locked <= 1'b0;
          state  <= SEARCH;
        end
        default: state <= SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_led_shift_monitor.sv
// tb_led_shift_monitor: scoreboard bench. A segment-level reference model
// predicts every output event from the stimulus slot list; a negedge monitor
// pops and compares whenever the DUT pulses step_pulse or an error.
module tb_led_shift_monitor;

  localparam int unsigned CLK_FREQ = 8;
  localparam int unsigned STEP     = CLK_FREQ / 4;
  localparam int unsigned TOL      = 0;
  localparam logic [7:0]  INIT     = 8'h1F;
  localparam int          LAT      = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  leds_in = '0;
  logic        err_clr = 1'b0;
  logic        locked;
  logic        step_pulse;
  logic [15:0] step_count;
  logic [2:0]  position;
  logic [7:0]  last_pattern;
  logic        pattern_err;
  logic        timing_err;
  logic        err_sticky;

  led_shift_monitor #(
    .CLK_FREQ    (CLK_FREQ),
    .STEP_CYCLES (STEP),
    .TOL         (TOL),
    .INIT_PATTERN(INIT),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .leds_in     (leds_in),
    .err_clr     (err_clr),
    .locked      (locked),
    .step_pulse  (step_pulse),
    .step_count  (step_count),
    .position    (position),
    .last_pattern(last_pattern),
    .pattern_err (pattern_err),
    .timing_err  (timing_err),
    .err_sticky  (err_sticky)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          t;
    logic        sp;
    logic        pe;
    logic        te;
    logic [15:0] sc;
    logic [2:0]  pos;
    logic [7:0]  last;
    logic        lk;
    logic        st;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] stim[$];
  int         base = 0;
  int         vectors = 0;
  int         miscompares = 0;

  function automatic logic [7:0] rotl(input logic [7:0] x);
    return {x[6:0], x[7]};
  endfunction

  function automatic logic [7:0] val(input int k);
    if (k < 0) return 8'h00;
    if (k >= stim.size()) return stim[stim.size()-1];
    return stim[k];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input int t, input logic sp, input logic pe, input logic te,
                         input logic [15:0] sc, input logic [2:0] pos,
                         input logic [7:0] last, input logic lk, input logic st);
    ev_t e;
    e.t = t; e.sp = sp; e.pe = pe; e.te = te; e.sc = sc;
    e.pos = pos; e.last = last; e.lk = lk; e.st = st;
    exp_q.push_back(e);
  endtask

  // Reference model: walks from change to change over the slot list.
  // mode 0 = hunting for INIT, 1 = first rotation pending, 2 = tracking.
  task automatic model(input int horizon, input logic st_in, output logic st_out);
    int          t, tc, mode;
    bit          found;
    logic [7:0]  prev;
    logic [15:0] sc;
    logic [2:0]  pos;
    logic        st, pe, te;
    t = 0; mode = 0; st = st_in; prev = '0; sc = '0; pos = '0;
    while (t < horizon) begin
      if (mode == 0) begin
        found = 0;
        for (int k = t; k < horizon; k++)
          if (!found && val(k) == INIT) begin tc = k; found = 1; end
        if (!found) break;
        prev = INIT; sc = '0; pos = '0; t = tc; mode = 1;
      end else if (mode == 1) begin
        found = 0;
        for (int k = t + 1; k < horizon; k++)
          if (!found && val(k) != prev) begin tc = k; found = 1; end
        if (!found) break;
        if (val(tc) == rotl(prev)) begin
          prev = val(tc); sc = sc + 16'd1; pos = pos + 3'd1;
          push_ev(tc, 1, 0, 0, sc, pos, prev, 1, st);
          t = tc; mode = 2;
        end else begin
          st = 1;
          push_ev(tc, 0, 1, 0, sc, pos, prev, 0, st);
          t = tc + 1; mode = 0;
        end
      end else begin
        tc = -1;
        for (int d = 1; d <= int'(STEP + TOL); d++)
          if (tc < 0 && val(t + d) != prev) tc = t + d;
        if (tc < 0) begin
          tc = t + int'(STEP + TOL);
          if (tc >= horizon) break;
          st = 1;
          push_ev(tc, 0, 0, 1, sc, pos, prev, 0, st);
          t = tc + 2; mode = 0;
        end else begin
          if (tc >= horizon) break;
          pe = (val(tc) != rotl(prev));
          te = ((tc - t) < int'(STEP - TOL));
          if (pe || te) begin
            st = 1;
            push_ev(tc, 0, pe, te, sc, pos, prev, 0, st);
            t = tc + 2; mode = 0;
          end else begin
            prev = val(tc);
            sc = (sc == 16'hFFFF) ? sc : sc + 16'd1;
            pos = pos + 3'd1;
            push_ev(tc, 1, 0, 0, sc, pos, prev, 1, st);
            t = tc;
          end
        end
      end
    end
    st_out = st;
  endtask

  task automatic push_seg(input logic [7:0] v, input int h);
    for (int i = 0; i < h; i++) stim.push_back(v);
  endtask

  task automatic play();
    for (int i = 0; i < stim.size(); i++) begin
      @(posedge clk); #1;
      if (i == 0) base = cyc;
      leds_in = stim[i];
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_locked"},       locked,       0);
    chk({tag, "_step_pulse"},   step_pulse,   0);
    chk({tag, "_step_count"},   step_count,   0);
    chk({tag, "_position"},     position,     0);
    chk({tag, "_last_pattern"}, last_pattern, 0);
    chk({tag, "_pattern_err"},  pattern_err,  0);
    chk({tag, "_timing_err"},   timing_err,   0);
    chk({tag, "_err_sticky"},   err_sticky,   0);
  endtask

  // Monitor: every DUT event must match the head of the expected queue
  always @(negedge clk) begin
    ev_t e;
    if (step_pulse || pattern_err || timing_err) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_event: step=%0b pat=%0b tim=%0b, expected no event (t=%0t)",
                 step_pulse, pattern_err, timing_err, $time);
      end else begin
        e = exp_q.pop_front();
        chk("event_cycle",  cyc - base,   e.t + LAT);
        chk("step_pulse",   step_pulse,   e.sp);
        chk("pattern_err",  pattern_err,  e.pe);
        chk("timing_err",   timing_err,   e.te);
        chk("step_count",   step_count,   e.sc);
        chk("position",     position,     e.pos);
        chk("last_pattern", last_pattern, e.last);
        chk("locked",       locked,       e.lk);
        chk("err_sticky",   err_sticky,   e.st);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] cur, v;
    logic       st_final, st_dummy;
    int         r, h;

    // Reset with INIT on the bus: everything stays zero
    rst = 1'b1; leds_in = INIT;
    repeat (3) @(posedge clk); #1;
    chk_all_zero("reset");
    leds_in = 8'h00;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("locked_after_release", locked, 0);

    // Directed prefix: lock, full lap, skipped step, stall, early change
    stim.delete();
    push_seg(8'h1F, 4);
    push_seg(8'h3E, 2); push_seg(8'h7C, 2); push_seg(8'hF8, 2); push_seg(8'hF1, 2);
    push_seg(8'hE3, 2); push_seg(8'hC7, 2); push_seg(8'h8F, 2); push_seg(8'h1F, 2);
    push_seg(8'h3E, 2); push_seg(8'hF8, 2);
    push_seg(8'h1F, 3); push_seg(8'h3E, 2); push_seg(8'h7C, 4);
    push_seg(8'h1F, 3); push_seg(8'h3E, 1); push_seg(8'h7C, 2);
    cur = 8'h7C;
    // Randomised continuation
    for (int s = 0; s < 150; s++) begin
      r = int'($urandom_range(0, 19));
      h = 2;
      if (r < 13)       v = rotl(cur);
      else if (r == 13) begin v = rotl(cur); h = 1; end
      else if (r == 14) begin v = rotl(cur); h = 3 + int'($urandom_range(0, 2)); end
      else if (r < 17)  v = rotl(rotl(cur));
      else if (r == 17) v = 8'($urandom);
      else begin v = INIT; h = 2 + int'($urandom_range(0, 2)); end
      push_seg(v, h);
      cur = v;
    end
    push_seg(cur, 10);
    model(stim.size(), 1'b0, st_final);
    play();
    repeat (30) @(posedge clk); #1;
    chk("queue_drained", exp_q.size(), 0);

    // Sticky error flag and its synchronous clear
    chk("sticky_before_clr", err_sticky, st_final);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("sticky_after_clr", err_sticky, 0);

    // Reset mid-track with step_count == 3
    rst = 1'b1; leds_in = 8'h00;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    stim.delete();
    push_seg(8'h1F, 4); push_seg(8'h3E, 2); push_seg(8'h7C, 2); push_seg(8'hF8, 2);
    model(9, 1'b0, st_dummy);
    play();
    for (int k = 0; k < 20 && step_count != 16'd3; k++) @(negedge clk);
    chk("count_before_reset", step_count, 3);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    leds_in = 8'h00;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(posedge clk); #1;
    chk("locked_after_mid_reset", locked, 0);
    chk("count_after_mid_reset", step_count, 0);
    chk("queue_empty_final", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/led_shift_monitor.md
Name: led_shift_monitor

Overview:
Receive-side checker for the rotating 8-bit LED shifter pattern. It synchronises a remote `leds` bus and locks onto the initial pattern. It then verifies that every change is exactly a one-bit left rotation arriving at the expected interval, and reports step count, position and errors. It sits on the board/bench side, opposite the LED shifter, and is driven by the same `leds` wires.

Parameters:
CLK_FREQ, 8, monitor clock frequency in Hz
STEP_CYCLES, CLK_FREQ/4, expected clk cycles between pattern changes; must be > TOL
TOL, 0, allowed ± deviation in cycles on each interval
INIT_PATTERN, 8'h1F, pattern that starts tracking
SYNC_STAGES, 2, synchroniser depth on leds_in; minimum 2

Ports:
clk  input  1  single system clock; all logic on rising edge
rst  input  1  reset, asynchronous, active-high
leds_in  input  8  remote LED bus, asynchronous to clk
err_clr  input  1  synchronous clear of err_sticky
locked  output  1  high while in TRACK
step_pulse  output  1  one-cycle pulse per accepted rotation
step_count  output  16  accepted rotations since lock; saturates at 16'hFFFF
position  output  3  rotation index mod 8; 0 = INIT_PATTERN
last_pattern  output  8  last accepted pattern
pattern_err  output  1  one-cycle pulse: change was not rotl(prev)
timing_err  output  1  one-cycle pulse: change early or overdue
err_sticky  output  1  set by any error pulse, cleared by err_clr or rst

Behaviour:
- Reset (async, rst=1):
  - Synchroniser flops, prev, cnt and all outputs are 0.
  - State is SEARCH.
- Synchronisation:
  - leds_s is leds_in delayed by SYNC_STAGES flops.
  - All decisions use leds_s.
  - All outputs are registered, so step_pulse/err pulses appear SYNC_STAGES+1 cycles after the leds_in edge.
- Definitions:
  - rotl(x) = {x[6:0], x[7]}.
  - change = (leds_s != prev).
  - cnt: set to 1 on each accepted change; +1 on each non-change cycle; saturates at 8'hFF.
  - At a change cycle, cnt equals the cycles since the previous change.
- SEARCH:
  - On leds_s == INIT_PATTERN: prev = INIT_PATTERN, last_pattern = INIT_PATTERN, position = 0, step_count = 0, cnt = 1, go to ALIGN.
- ALIGN (no timing check; the hold time of INIT after the remote reset is unknown):
  - On change with leds_s == rotl(prev): accept, go to TRACK.
  - On change otherwise: pattern_err pulse, go to SEARCH.
- Accept:
  - prev and last_pattern take leds_s.
  - step_pulse = 1.
  - step_count +1 (saturating).
  - position +1 (wraps 7→0).
  - cnt = 1.
- TRACK:
  - Change, valid rotation, STEP_CYCLES−TOL ≤ cnt ≤ STEP_CYCLES+TOL: accept, stay in TRACK.
  - Change, leds_s != rotl(prev): pattern_err pulse, go to FAULT.
  - Change, cnt < STEP_CYCLES−TOL: timing_err pulse, go to FAULT.
  - Both faults in the same cycle: both pulses fire in that cycle.
  - Non-change cycle with cnt == STEP_CYCLES+TOL: overdue, timing_err pulse, go to FAULT.
  - Wrap back to INIT_PATTERN is a normal step: position = 0, no error.
- FAULT:
  - locked = 0.
  - Go to SEARCH on the next cycle; prev is not updated.
- err_sticky:
  - Set on any error pulse; this takes priority over err_clr in the same cycle.
  - Otherwise cleared by err_clr.
- Reset mid-operation: immediate return to reset values; no pulse is generated on release.

Test Plan:
- Reset: hold rst=1 with leds_in = 8'h1F → all outputs 0. After release, locked=0 until the first step.
- CLK_FREQ=8 (STEP=2, TOL=0): leds_in 8'h1F, then 8'h3E, 8'h7C, 8'hF8, 8'hF1, each held 2 cycles:
  - 4 step_pulses, 2 cycles apart, first pulse 3 cycles after the 8'h3E edge.
  - Final step_count=4, position=4, last_pattern=8'hF1, locked=1, no errors.
- Full lap: 8 rotations returning to 8'h1F → position=0, step_count=8, err_sticky=0.
- Skipped step: in TRACK, 8'h3E followed by 8'hF8 → pattern_err one-cycle pulse, err_sticky=1, locked=0. Tracking relocks after 8'h1F is reapplied.
- Stall/early:
  - Hold 8'h7C for 3+ cycles → timing_err when cnt==2 with no change.
  - Change after 1 cycle → timing_err, err_sticky=1.
  - Then err_clr=1 for 1 cycle → err_sticky=0.
- Reset mid-track: assert rst asynchronously while step_count=3 → outputs 0 immediately, state SEARCH, no spurious pulses after release.
